// File: rtl/uart_calc_fsm.sv
// Serial command/response calculator: parses "<op><hex digits>\r\n" frames, updates a
// persistent accumulator and streams back a ROM message, the accumulator in hex, then CR LF.
module uart_calc_fsm #(
    parameter int unsigned       DW     = 28,
    parameter int unsigned       RW     = 84,
    parameter int unsigned       AW     = 7,
    parameter logic [AW-1:0]     MSG_A0 = 7'h00,
    parameter logic [AW-1:0]     MSG_A1 = 7'h07,
    parameter logic [4*AW-1:0]   ERR_A0 = {7'h43, 7'h2C, 7'h1A, 7'h08},
    parameter logic [4*AW-1:0]   ERR_A1 = {7'h4A, 7'h42, 7'h2B, 7'h19}
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          RX_DATA_EN,
    input  logic [9:0]    RX_DATA_R,
    output logic          TX_RDY_T,
    output logic [7:0]    TX_DATA_T,
    input  logic          TX_RDY_R,
    output logic [7:0]    ASCII_DATA,
    input  logic          HEX_FLG,
    input  logic [3:0]    DC_HEX_DATA,
    output logic [3:0]    HEX_DATA,
    input  logic [7:0]    DC_ASCII_DATA,
    output logic [AW-1:0] ADDR,
    input  logic [7:0]    DATA
);

    localparam int unsigned ND = DW / 4;
    localparam int unsigned NR = RW / 4;
    localparam int unsigned CW = $clog2(NR + 1);

    localparam logic [7:0] OpAdd = 8'h2B;
    localparam logic [7:0] OpSub = 8'h2D;
    localparam logic [7:0] OpXor = 8'h5E;
    localparam logic [7:0] OpSet = 8'h3D;
    localparam logic [7:0] OpClr = 8'h43;
    localparam logic [7:0] ChCr  = 8'h0D;
    localparam logic [7:0] ChLf  = 8'h0A;

    typedef enum logic [2:0] {
        StIdle, StRdt, StRlf, StTres, StTmem, StTdt, StTcr, StTlf
    } state_e;

    state_e          state_q, state_d;
    logic            tx_rdy_q, tx_rdy_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   end_q, end_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   opr_q, opr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      op_q, op_d;
    logic            res_flg_q, res_flg_d;

    logic [7:0]      rx_byte;
    logic [1:0]      err_code;
    logic            rx_err;
    logic            err;
    logic            op_valid;
    logic [RW-1:0]   opr_ext;
    logic [RW-1:0]   acc_new;

    assign rx_byte    = RX_DATA_R[7:0];
    assign err_code   = RX_DATA_R[9:8];
    assign rx_err     = |err_code;
    assign ASCII_DATA = rx_byte;
    assign TX_RDY_T   = tx_rdy_q;
    assign TX_DATA_T  = tx_data_q;
    assign ADDR       = addr_q;

    assign op_valid = (rx_byte == OpAdd) || (rx_byte == OpSub) || (rx_byte == OpXor) ||
                      (rx_byte == OpSet) || (rx_byte == OpClr);

    always_comb begin
        opr_ext           = '0;
        opr_ext[DW-1:0]   = opr_q;
    end

    always_comb begin
        case (op_q)
            OpAdd:   acc_new = acc_q + opr_ext;
            OpSub:   acc_new = acc_q - opr_ext;
            OpXor:   acc_new = acc_q ^ opr_ext;
            OpSet:   acc_new = opr_ext;
            OpClr:   acc_new = '0;
            default: acc_new = acc_q;
        endcase
    end

    // Digit index 0 is the most significant accumulator nibble.
    always_comb begin
        HEX_DATA = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (cnt_q == CW'(NR - 1 - i)) HEX_DATA = acc_q[i*4 +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_rdy_d  = tx_rdy_q;
        tx_data_d = tx_data_q;
        addr_d    = addr_q;
        end_d     = end_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        res_flg_d = res_flg_q;
        err       = 1'b0;

        case (state_q)
            StIdle: begin
                if (RX_DATA_EN) begin
                    if (!rx_err && op_valid) begin
                        state_d = StRdt;
                        op_d    = rx_byte;
                        opr_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            StRdt: begin
                if (RX_DATA_EN) begin
                    if (rx_err) begin
                        err = 1'b1;
                    end else if (HEX_FLG) begin
                        if (op_q == OpClr || cnt_q == CW'(ND)) begin
                            err = 1'b1;
                        end else begin
                            opr_d = {opr_q[DW-5:0], DC_HEX_DATA};
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (rx_byte == ChCr && (cnt_q != '0 || op_q == OpClr)) begin
                        state_d = StRlf;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            StRlf: begin
                if (RX_DATA_EN) begin
                    if (!rx_err && rx_byte == ChLf) begin
                        acc_d     = acc_new;
                        addr_d    = MSG_A0;
                        end_d     = MSG_A1;
                        res_flg_d = 1'b1;
                        state_d   = StTres;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            StTres: begin
                tx_data_d = DATA;
                tx_rdy_d  = 1'b1;
                addr_d    = addr_q + AW'(1);
                cnt_d     = '0;
                state_d   = StTmem;
            end
            StTmem: begin
                if (TX_RDY_R) begin
                    if (addr_q == end_q + AW'(1)) begin
                        if (res_flg_q) begin
                            state_d   = StTdt;
                            tx_data_d = DC_ASCII_DATA;
                            cnt_d     = CW'(1);
                        end else begin
                            state_d   = StTcr;
                            tx_data_d = ChCr;
                        end
                    end else begin
                        tx_data_d = DATA;
                        addr_d    = addr_q + AW'(1);
                    end
                end
            end
            StTdt: begin
                // cnt_q indexes the next digit to load once the current one is accepted.
                if (TX_RDY_R) begin
                    if (cnt_q == CW'(NR)) begin
                        state_d   = StTcr;
                        tx_data_d = ChCr;
                        cnt_d     = '0;
                    end else begin
                        tx_data_d = DC_ASCII_DATA;
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
            end
            StTcr: begin
                if (TX_RDY_R) begin
                    state_d   = StTlf;
                    tx_data_d = ChLf;
                end
            end
            StTlf: begin
                if (TX_RDY_R) begin
                    state_d  = StIdle;
                    tx_rdy_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (err) begin
            addr_d    = ERR_A0[32'(err_code)*AW +: AW];
            end_d     = ERR_A1[32'(err_code)*AW +: AW];
            res_flg_d = 1'b0;
            state_d   = StTres;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            tx_rdy_q  <= 1'b0;
            tx_data_q <= '0;
            addr_q    <= '0;
            end_q     <= '0;
            acc_q     <= '0;
            opr_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            res_flg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_rdy_q  <= tx_rdy_d;
            tx_data_q <= tx_data_d;
            addr_q    <= addr_d;
            end_q     <= end_d;
            acc_q     <= acc_d;
            opr_q     <= opr_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            res_flg_q <= res_flg_d;
        end
    end

endmodule

// File: tb/tb_uart_calc_fsm.sv
// Directed bench for uart_calc_fsm: drives command frames, collects replies and compares them
// against hand-written expected strings, with ROM and hex codecs modelled locally.
module tb_uart_calc_fsm;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX_DATA_EN = 1'b0;
    logic [9:0] RX_DATA_R = '0;
    logic       TX_RDY_T;
    logic [7:0] TX_DATA_T;
    logic       TX_RDY_R = 1'b0;
    logic [7:0] ASCII_DATA;
    logic       HEX_FLG;
    logic [3:0] DC_HEX_DATA;
    logic [3:0] HEX_DATA;
    logic [7:0] DC_ASCII_DATA;
    logic [6:0] ADDR;
    logic [7:0] DATA;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rsp[$];
    logic [7:0] exp_q[$];

    uart_calc_fsm dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .RX_DATA_EN    (RX_DATA_EN),
        .RX_DATA_R     (RX_DATA_R),
        .TX_RDY_T      (TX_RDY_T),
        .TX_DATA_T     (TX_DATA_T),
        .TX_RDY_R      (TX_RDY_R),
        .ASCII_DATA    (ASCII_DATA),
        .HEX_FLG       (HEX_FLG),
        .DC_HEX_DATA   (DC_HEX_DATA),
        .HEX_DATA      (HEX_DATA),
        .DC_ASCII_DATA (DC_ASCII_DATA),
        .ADDR          (ADDR),
        .DATA          (DATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom(input logic [6:0] a);
        return (8'(a) * 8'd37) ^ 8'hA5;
    endfunction

    assign DATA          = rom(ADDR);
    assign DC_ASCII_DATA = (HEX_DATA < 4'd10) ? 8'h30 + {4'h0, HEX_DATA}
                                              : 8'h37 + {4'h0, HEX_DATA};

    always_comb begin
        HEX_FLG     = 1'b1;
        DC_HEX_DATA = '0;
        if (ASCII_DATA >= 8'h30 && ASCII_DATA <= 8'h39)      DC_HEX_DATA = 4'(ASCII_DATA - 8'h30);
        else if (ASCII_DATA >= 8'h41 && ASCII_DATA <= 8'h46) DC_HEX_DATA = 4'(ASCII_DATA - 8'h37);
        else if (ASCII_DATA >= 8'h61 && ASCII_DATA <= 8'h66) DC_HEX_DATA = 4'(ASCII_DATA - 8'h57);
        else HEX_FLG = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic string pad(input string s);
        string r = s;
        while (r.len() < 21) r = {"0", r};
        return r;
    endfunction

    task automatic send_byte(input logic [9:0] b);
        @(negedge CLK);
        RX_DATA_EN = 1'b1;
        RX_DATA_R  = b;
        @(negedge CLK);
        RX_DATA_EN = 1'b0;
        RX_DATA_R  = '0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte({2'b00, s[i]});
    endtask

    task automatic send_cmd(input string s);
        send_str(s);
        send_byte(10'h00D);
        send_byte(10'h00A);
    endtask

    task automatic wait_rdy(input string tag);
        int g = 0;
        while (!TX_RDY_T && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (!TX_RDY_T) check({tag, "_start"}, 64'(TX_RDY_T), 64'd1);
    endtask

    task automatic accept(input int n);
        for (int i = 0; i < n && TX_RDY_T; i++) begin
            rsp.push_back(TX_DATA_T);
            TX_RDY_R = 1'b1;
            @(negedge CLK);
            TX_RDY_R = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic collect(input string tag, input bit clear);
        if (clear) rsp.delete();
        wait_rdy(tag);
        accept(400);
        check({tag, "_rdy_low"}, 64'(TX_RDY_T), 64'd0);
    endtask

    task automatic expect_reply(input string tag, input int a0, input int a1, input string dg);
        int n;
        exp_q.delete();
        for (int a = a0; a <= a1; a++) exp_q.push_back(rom(7'(a)));
        for (int i = 0; i < dg.len(); i++) exp_q.push_back(dg[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check({tag, "_len"}, 64'(rsp.size()), 64'(exp_q.size()));
        n = (rsp.size() < exp_q.size()) ? rsp.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 64'(rsp[i]), 64'(exp_q[i]));
    endtask

    task automatic cmd_reply(input string tag, input string cmd, input string dg);
        send_cmd(cmd);
        collect(tag, 1'b1);
        expect_reply(tag, 0, 7, dg);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hold;
        bit         stable;

        repeat (3) @(negedge CLK);
        check("rst_rdy", 64'(TX_RDY_T), 64'd0);
        check("rst_data", 64'(TX_DATA_T), 64'd0);
        check("rst_addr", 64'(ADDR), 64'd0);
        RST_N = 1'b1;

        cmd_reply("sub1", "-0000001", {"FFFFFFFFFF", "FFFFFFFFFF", "F"});
        cmd_reply("clr0", "C", pad(""));
        cmd_reply("addA", "+A", pad("A"));
        cmd_reply("add6", "+6", pad("10"));
        cmd_reply("set", "=1234567", pad("1234567"));
        cmd_reply("xor", "^FFFFFFF", pad("EDCBA98"));

        send_str("+12345678");
        collect("ovf", 1'b1);
        expect_reply("ovf", 8'h08, 8'h19, "");
        cmd_reply("after_ovf", "+1", pad("EDCBA99"));

        send_str("+1");
        send_byte(10'h231);
        collect("rxe2", 1'b1);
        expect_reply("rxe2", 8'h2C, 8'h42, "");
        cmd_reply("after_rxe2", "+0", pad("EDCBA99"));

        send_byte(10'h32B);
        collect("rxe3", 1'b1);
        expect_reply("rxe3", 8'h43, 8'h4A, "");
        send_str("=");
        send_byte(10'h141);
        collect("rxe1", 1'b1);
        expect_reply("rxe1", 8'h1A, 8'h2B, "");
        send_str("x");
        collect("badop", 1'b1);
        expect_reply("badop", 8'h08, 8'h19, "");
        send_str("+");
        send_byte(10'h00D);
        collect("nodig", 1'b1);
        expect_reply("nodig", 8'h08, 8'h19, "");
        send_str("C5");
        collect("clrdig", 1'b1);
        expect_reply("clrdig", 8'h08, 8'h19, "");
        send_str("+1");
        send_byte(10'h00D);
        send_byte(10'h00D);
        collect("nolf", 1'b1);
        expect_reply("nolf", 8'h08, 8'h19, "");
        cmd_reply("clr1", "C", pad(""));

        // Stall the transmitter mid-message while the receiver keeps strobing.
        send_cmd("=ABC");
        rsp.delete();
        wait_rdy("stall");
        accept(3);
        hold   = TX_DATA_T;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (TX_DATA_T !== hold || TX_RDY_T !== 1'b1) stable = 1'b0;
            RX_DATA_EN = (i % 10 == 0);
            RX_DATA_R  = 10'h02B;
        end
        RX_DATA_EN = 1'b0;
        RX_DATA_R  = '0;
        check("stall_stable", 64'(stable), 64'd1);
        collect("stall", 1'b0);
        expect_reply("stall", 0, 7, pad("ABC"));
        cmd_reply("after_stall", "+1", pad("ABD"));

        send_cmd("+1");
        rsp.delete();
        wait_rdy("midrst");
        accept(11);
        RST_N = 1'b0;
        #1;
        check("midrst_rdy", 64'(TX_RDY_T), 64'd0);
        check("midrst_data", 64'(TX_DATA_T), 64'd0);
        check("midrst_addr", 64'(ADDR), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cmd_reply("after_rst", "+0", pad(""));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
